// File: rtl/pe_exec_unit.sv
// SIMD PE execution unit: lane-wise ALU stage, dot-product adder tree and store/stop drain FSM.
// Optional build macro PE_SATURATE_EN: signed saturation for ADD and SUB (MUL/DOTP always wrap).
module pe_exec_unit #(
  parameter int DATA_LEN      = 32,
  parameter int PE_ELEMENTS   = 4,
  parameter int PE_OPCODE_LEN = 4
) (
  input  logic                            clk,
  input  logic                            rstn,
  input  logic [PE_OPCODE_LEN-1:0]        pe_opcode,
  input  logic                            load_a,
  input  logic                            load_b,
  input  logic [PE_ELEMENTS*DATA_LEN-1:0] data_a,
  input  logic [PE_ELEMENTS*DATA_LEN-1:0] data_b,
  output logic [PE_ELEMENTS*DATA_LEN-1:0] pe_stage_1_output,
  output logic                            pe_stage_1_valid,
  output logic [DATA_LEN-1:0]             pe_stage_2_output,
  output logic                            pe_stage_2_valid,
  output logic                            store_result,
  output logic                            pe_done
);

  localparam int VEC_W      = PE_ELEMENTS * DATA_LEN;
  localparam int TREE_NODES = 2 * PE_ELEMENTS - 1;

  localparam logic [PE_OPCODE_LEN-1:0] OP_ADD           = PE_OPCODE_LEN'(1);
  localparam logic [PE_OPCODE_LEN-1:0] OP_SUB           = PE_OPCODE_LEN'(2);
  localparam logic [PE_OPCODE_LEN-1:0] OP_MUL           = PE_OPCODE_LEN'(3);
  localparam logic [PE_OPCODE_LEN-1:0] OP_DOTP          = PE_OPCODE_LEN'(4);
  localparam logic [PE_OPCODE_LEN-1:0] OP_STORE_TEMP_S1 = PE_OPCODE_LEN'(5);
  localparam logic [PE_OPCODE_LEN-1:0] OP_STORE_TEMP_S2 = PE_OPCODE_LEN'(6);
  localparam logic [PE_OPCODE_LEN-1:0] OP_STORE_RESULT  = PE_OPCODE_LEN'(7);
  localparam logic [PE_OPCODE_LEN-1:0] OP_STOP          = PE_OPCODE_LEN'(8);

  typedef enum logic [1:0] {
    ST_RUN         = 2'd0,
    ST_DRAIN_STORE = 2'd1,
    ST_DRAIN_STOP  = 2'd2
  } state_t;

  state_t              state_reg;
  logic [VEC_W-1:0]    a_reg;
  logic [VEC_W-1:0]    b_reg;
  logic [VEC_W-1:0]    s1_out_reg;
  logic [VEC_W-1:0]    prod_reg;
  logic                s1_valid_reg;
  logic                dotp_s1_reg;
  logic [DATA_LEN-1:0] s2_out_reg;
  logic                s2_valid_reg;
  logic                store_result_reg;
  logic                done_reg;

  logic [VEC_W-1:0]    alu_next;
  logic [VEC_W-1:0]    prod_next;
  logic [DATA_LEN-1:0] tree_node [TREE_NODES];
  logic [DATA_LEN-1:0] dotp_sum;
  logic                pipe_busy;

  genvar gi;
  generate
    for (gi = 0; gi < PE_ELEMENTS; gi++) begin : g_lane
      logic [DATA_LEN-1:0] a_lane;
      logic [DATA_LEN-1:0] b_lane;
      logic [DATA_LEN-1:0] sum_w;
      logic [DATA_LEN-1:0] diff_w;
      logic [DATA_LEN-1:0] prod_w;
      logic [DATA_LEN-1:0] add_res;
      logic [DATA_LEN-1:0] sub_res;
      logic [DATA_LEN-1:0] alu_lane;

      assign a_lane = a_reg[gi*DATA_LEN +: DATA_LEN];
      assign b_lane = b_reg[gi*DATA_LEN +: DATA_LEN];
      assign sum_w  = a_lane + b_lane;
      assign diff_w = a_lane - b_lane;
      assign prod_w = a_lane * b_lane;

`ifdef PE_SATURATE_EN
      // Overflow only when the true result sign cannot match; clamp toward the sign of A.
      logic add_ovf;
      logic sub_ovf;
      assign add_ovf = (a_lane[DATA_LEN-1] == b_lane[DATA_LEN-1]) &&
                       (sum_w[DATA_LEN-1] != a_lane[DATA_LEN-1]);
      assign sub_ovf = (a_lane[DATA_LEN-1] != b_lane[DATA_LEN-1]) &&
                       (diff_w[DATA_LEN-1] != a_lane[DATA_LEN-1]);
      assign add_res = add_ovf ? {~a_lane[DATA_LEN-1], {(DATA_LEN-1){a_lane[DATA_LEN-1]}}} : sum_w;
      assign sub_res = sub_ovf ? {~a_lane[DATA_LEN-1], {(DATA_LEN-1){a_lane[DATA_LEN-1]}}} : diff_w;
`else
      assign add_res = sum_w;
      assign sub_res = diff_w;
`endif

      always_comb begin
        alu_lane = add_res;
        case (pe_opcode)
          OP_SUB:  alu_lane = sub_res;
          OP_MUL:  alu_lane = prod_w;
          default: alu_lane = add_res;
        endcase
      end

      assign alu_next[gi*DATA_LEN +: DATA_LEN]  = alu_lane;
      assign prod_next[gi*DATA_LEN +: DATA_LEN] = prod_w;
    end
  endgenerate

  // Binary adder tree: leaves at PE_ELEMENTS-1.., node k sums children 2k+1 and 2k+2, root at 0.
  always_comb begin
    for (int i = 0; i < TREE_NODES; i++) begin
      tree_node[i] = '0;
    end
    for (int i = 0; i < PE_ELEMENTS; i++) begin
      tree_node[PE_ELEMENTS-1+i] = prod_reg[i*DATA_LEN +: DATA_LEN];
    end
    for (int k = PE_ELEMENTS - 2; k >= 0; k--) begin
      tree_node[k] = tree_node[2*k+1] + tree_node[2*k+2];
    end
  end

  assign dotp_sum  = tree_node[0];
  // Only a DOTP sitting in the product stage still owes a future valid pulse.
  assign pipe_busy = dotp_s1_reg;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_reg        <= ST_RUN;
      a_reg            <= '0;
      b_reg            <= '0;
      s1_out_reg       <= '0;
      prod_reg         <= '0;
      s1_valid_reg     <= 1'b0;
      dotp_s1_reg      <= 1'b0;
      s2_out_reg       <= '0;
      s2_valid_reg     <= 1'b0;
      store_result_reg <= 1'b0;
      done_reg         <= 1'b0;
    end else begin
      s1_valid_reg     <= 1'b0;
      dotp_s1_reg      <= 1'b0;
      s2_valid_reg     <= 1'b0;
      store_result_reg <= 1'b0;
      done_reg         <= 1'b0;

      if (load_a) begin
        a_reg <= data_a;
      end
      if (load_b) begin
        b_reg <= data_b;
      end

      if (dotp_s1_reg) begin
        s2_out_reg   <= dotp_sum;
        s2_valid_reg <= 1'b1;
      end

      case (state_reg)
        ST_RUN: begin
          case (pe_opcode)
            OP_ADD, OP_SUB, OP_MUL: begin
              s1_out_reg   <= alu_next;
              s1_valid_reg <= 1'b1;
            end
            OP_DOTP: begin
              prod_reg    <= prod_next;
              dotp_s1_reg <= 1'b1;
            end
            // Chaining ops take precedence over a simultaneous load_a.
            OP_STORE_TEMP_S1: a_reg <= s1_out_reg;
            OP_STORE_TEMP_S2: a_reg <= {a_reg[VEC_W-DATA_LEN-1:0], s2_out_reg};
            OP_STORE_RESULT: begin
              if (pipe_busy) begin
                state_reg <= ST_DRAIN_STORE;
              end else begin
                store_result_reg <= 1'b1;
              end
            end
            OP_STOP: begin
              if (pipe_busy) begin
                state_reg <= ST_DRAIN_STOP;
              end else begin
                done_reg <= 1'b1;
              end
            end
            default: ;
          endcase
        end
        ST_DRAIN_STORE: begin
          if (!pipe_busy) begin
            store_result_reg <= 1'b1;
            state_reg        <= ST_RUN;
          end
        end
        ST_DRAIN_STOP: begin
          if (!pipe_busy) begin
            done_reg  <= 1'b1;
            state_reg <= ST_RUN;
          end
        end
        default: state_reg <= ST_RUN;
      endcase
    end
  end

  assign pe_stage_1_output = s1_out_reg;
  assign pe_stage_1_valid  = s1_valid_reg;
  assign pe_stage_2_output = s2_out_reg;
  assign pe_stage_2_valid  = s2_valid_reg;
  assign store_result      = store_result_reg;
  assign pe_done           = done_reg;

endmodule
